pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage datapath: drives write-enables, flushes and bubble
//  insertion for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Handles load-use stalls, taken-branch
//  flushes and data-memory wait freezes. Includes a memory-wait watchdog and saturating
//  performance counters. Sits in the top-level CPU beside the stage registers.
// PARAMETERS
//  MEM_TIMEOUT  8   consecutive dmem_busy cycles that trigger a fault (>=2)
//  CNT_W        16  width of the stall and flush performance counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset (0 = reset)
//  id_rs        in   5      rs field of the instruction in ID
//  id_rt        in   5      rt field of the instruction in ID
//  id_uses_rt   in   1      ID instruction reads rt as a source operand
//  ex_mem_read  in   1      mem_read control bit currently held in ID/EX
//  ex_rt        in   5      rt (load destination) currently held in ID/EX
//  branch_taken in   1      branch resolved taken in ID this cycle
//  dmem_busy    in   1      data memory not ready; MEM stage must hold
//  cnt_clr      in   1      synchronous clear of both perf counters
//  pc_write     out  1      PC load enable
//  if_id_write  out  1      IF/ID load enable
//  if_id_flush  out  1      IF/ID loads a NOP
//  id_ex_write  out  1      ID/EX load enable
//  id_ex_bubble out  1      ID/EX loads all-zero control fields (data fields don't care)
//  exmem_write  out  1      EX/MEM load enable
//  memwb_write  out  1      MEM/WB load enable
//  fault        out  1      sticky memory-timeout fault
//  stall_cnt    out  CNT_W  cycles with pc_write=0 (saturating)
//  flush_cnt    out  CNT_W  cycles with if_id_flush=1 (saturating)
// BEHAVIOUR
//  - Hazard term: load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//  - FSM states are RUN, MEM_WAIT and FAULT; wait_cnt is a registered counter, ceil(log2(MEM_TIMEOUT+1)) bits.
//  - Outputs are combinational from the state and the current inputs (Mealy). Priority,
//    highest first, is FAULT > dmem_busy > load_use > branch_taken > normal.
//  - FAULT: all write enables 0, flush=0, bubble=0, fault=1.
//  - Freeze (dmem_busy=1, not FAULT): all five write enables 0, flush=0, bubble=0.
//  - Load-use stall: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1;
//    exmem_write=memwb_write=1. Lasts exactly one cycle: the bubble clears ex_mem_read.
//    branch_taken is ignored in this cycle, because the branch operand is not yet ready.
//  - Branch flush: pc_write=1, if_id_write=1, if_id_flush=1; all others write, bubble=0.
//  - Normal: all write enables 1, flush=0, bubble=0.
//  - RUN->MEM_WAIT when dmem_busy=1. In that transition cycle wait_cnt is set to 1.
//  - MEM_WAIT: while dmem_busy=1, wait_cnt increments. When dmem_busy=1 and wait_cnt==MEM_TIMEOUT-1,
//    the next state is FAULT. When dmem_busy=0, the outputs follow the RUN rules in that same
//    cycle, the next state is RUN and wait_cnt is cleared to 0.
//  - FAULT is left only by reset; dmem_busy dropping does not clear it.
//  - Counters: stall_cnt +1 in every cycle with pc_write=0, including FAULT cycles. flush_cnt +1 in
//    every cycle with if_id_flush=1. Both saturate at 2^CNT_W-1. cnt_clr takes priority over
//    the increment, and the count reads 0 on the next edge.
//  - Reset (rst=0, async): state=RUN, wait_cnt=0, fault=0, stall_cnt=0, flush_cnt=0.
//    With quiet inputs (all single-bit inputs 0), outputs read pc_write=if_id_write=id_ex_write=exmem_write=memwb_write=1,
//    and if_id_flush=id_ex_bubble=0. Reset asserted mid-MEM_WAIT or mid-FAULT returns
//    the block to RUN immediately.
// TESTING
//  1) ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0,
//     id_ex_bubble=1 for that cycle only; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
//  2) id_rt=7, ex_rt=7, ex_mem_read=1: with id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
//  3) branch_taken=1 alone -> if_id_flush=1, flush_cnt=1. branch_taken=1 together with load_use
//     -> stall, if_id_flush=0, flush_cnt unchanged.
//  4) dmem_busy=1 for 3 cycles, load_use also high -> all enables 0 for 3 cycles, bubble=0,
//     stall_cnt=3. Next cycle the stall takes effect, and the state is back in RUN.
//  5) MEM_TIMEOUT=8, dmem_busy held high -> fault=1 from the 9th busy cycle; it stays 1 after
//     dmem_busy=0. Drive rst=0 mid-FAULT -> fault=0, counters 0, state RUN.
//  6) CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds at 15. Then cnt_clr=1 together
//     with a stall -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: stage enables, flush and bubble control,
// data-memory wait watchdog and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             branch_taken,
   input  logic             dmem_busy,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              load_use;

   // A load in EX whose destination is a source of the instruction in ID.
   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state and Mealy outputs; priority fault > busy > load-use > branch > normal.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      exmem_write  = 1'b1;
      memwb_write  = 1'b1;
      fault        = 1'b0;

      if (state_q == ST_FAULT) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         exmem_write = 1'b0;
         memwb_write = 1'b0;
         fault       = 1'b1;
      end else if (dmem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         exmem_write = 1'b0;
         memwb_write = 1'b0;
         if (state_q != ST_MEM_WAIT) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
         end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
               state_d = ST_FAULT;
            end
         end
      end else begin
         state_d    = ST_RUN;
         wait_cnt_d = '0;
         if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (branch_taken) begin
            if_id_flush = 1'b1;
         end
      end
   end

   // Saturating counters; clear wins over increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
